// File: rtl/regfile_issue_pkg.sv
// Shared sizing and op encoding for the operand-issue stage and the add/sub ALU.
package regfile_issue_pkg;
   localparam int WIDTH = 8;
   localparam int NREGS = 4;
   localparam int AW    = 2;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/regfile_core.sv
// Register array: two combinational read ports with write-back bypass, one write port.
module regfile_core
   import regfile_issue_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    rd_addr_a,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_a,
   output logic [WIDTH-1:0] rd_data_b,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data
);
   logic [WIDTH-1:0] regs [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // A write landing this cycle is forwarded so the issued operand is never stale.
   always_comb begin
      rd_data_a = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
      rd_data_b = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
   end
endmodule

// File: rtl/regfile_issue.sv
// Operand-issue stage: scoreboarded register reads, registered operands to the ALU.
module regfile_issue
   import regfile_issue_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [AW-1:0]    issue_rs_a,
   input  logic [AW-1:0]    issue_rs_b,
   input  logic [AW-1:0]    issue_rd,
   input  logic             issue_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_op,
   output logic [AW-1:0]    out_rd,
   input  logic             wb_en,
   input  logic [AW-1:0]    wb_addr,
   input  logic [WIDTH-1:0] wb_data,
   output logic [NREGS-1:0] pending
);
   logic [WIDTH-1:0] rd_a, rd_b;
   logic             hazard, accept;
   logic             vld_p0;
   logic [WIDTH-1:0] a_p0, b_p0;
   logic             op_p0;
   logic [AW-1:0]    rd_p0;
   logic [NREGS-1:0] pend_p0, pend_nxt;

   // A pending bit being cleared by this cycle's write-back no longer blocks issue.
   function automatic logic busy(input logic [NREGS-1:0] p, input logic [AW-1:0] r,
                                 input logic clr, input logic [AW-1:0] clr_addr);
      return p[r] && !(clr && clr_addr == r);
   endfunction

   always_comb begin
      hazard = busy(pend_p0, issue_rs_a, wb_en, wb_addr) ||
               busy(pend_p0, issue_rs_b, wb_en, wb_addr) ||
               busy(pend_p0, issue_rd,   wb_en, wb_addr);
   end

   assign issue_ready = (!vld_p0 || out_ready) && !hazard;
   assign accept      = issue_valid && issue_ready;

   // Set after clear: a newly issued destination stays pending.
   always_comb begin
      pend_nxt = pend_p0;
      if (wb_en)  pend_nxt[wb_addr]  = 1'b0;
      if (accept) pend_nxt[issue_rd] = 1'b1;
   end

   regfile_core u_core (
      .clk       (clk),
      .rst       (rst),
      .rd_addr_a (issue_rs_a),
      .rd_addr_b (issue_rs_b),
      .rd_data_a (rd_a),
      .rd_data_b (rd_b),
      .wr_en     (wb_en),
      .wr_addr   (wb_addr),
      .wr_data   (wb_data)
   );

   // Stage p0: operand register presented to the ALU
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p0  <= 1'b0;
         pend_p0 <= '0;
         a_p0    <= '0;
         b_p0    <= '0;
         op_p0   <= 1'b0;
         rd_p0   <= '0;
      end else begin
         pend_p0 <= pend_nxt;
         if (accept) begin
            vld_p0 <= 1'b1;
            a_p0   <= rd_a;
            b_p0   <= rd_b;
            op_p0  <= issue_op;
            rd_p0  <= issue_rd;
         end else if (out_ready) begin
            vld_p0 <= 1'b0;
         end
      end
   end

   assign out_valid = vld_p0;
   assign out_a     = a_p0;
   assign out_b     = b_p0;
   assign out_op    = op_p0;
   assign out_rd    = rd_p0;
   assign pending   = pend_p0;
endmodule

// File: tb/tb_regfile_issue.sv
// Directed bench for regfile_issue with an expected-operation scoreboard.
module tb_regfile_issue;
   import regfile_issue_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             issue_valid = 1'b0;
   logic             issue_ready;
   logic [AW-1:0]    issue_rs_a = '0, issue_rs_b = '0, issue_rd = '0;
   logic             issue_op = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] out_a, out_b;
   logic             out_op;
   logic [AW-1:0]    out_rd;
   logic             wb_en = 1'b0;
   logic [AW-1:0]    wb_addr = '0;
   logic [WIDTH-1:0] wb_data = '0;
   logic [NREGS-1:0] pending;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             op;
      logic [AW-1:0]    rd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic acc_prev = 1'b0;

   regfile_issue dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_rs_a(issue_rs_a), .issue_rs_b(issue_rs_b), .issue_rd(issue_rd), .issue_op(issue_op),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic op, input logic [AW-1:0] rd);
      exp_t e;
      e.a = a; e.b = b; e.op = op; e.rd = rd;
      sb.push_back(e);
   endtask

   task automatic offer(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        input logic [AW-1:0] rd, input logic op);
      issue_valid = 1'b1;
      issue_rs_a = ra; issue_rs_b = rb; issue_rd = rd; issue_op = op;
   endtask

   task automatic wb(input logic [AW-1:0] addr, input logic [WIDTH-1:0] data);
      wb_en = 1'b1; wb_addr = addr; wb_data = data;
   endtask

   // Pops one expected operation per accepted issue, one cycle after the accepting edge.
   always @(negedge clk) begin
      exp_t e;
      if (acc_prev) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sb_valid", 32'(out_valid), 32'd1);
            chk("sb_a",     32'(out_a),     32'(e.a));
            chk("sb_b",     32'(out_b),     32'(e.b));
            chk("sb_op",    32'(out_op),    32'(e.op));
            chk("sb_rd",    32'(out_rd),    32'(e.rd));
         end
      end
      acc_prev = !rst && issue_valid && issue_ready;
   end

   initial begin
      // Reset mid-cycle, observed without a clock edge
      cyc(); cyc();
      #3 rst = 1'b1;
      #1;
      chk("rst_valid",   32'(out_valid), 32'd0);
      chk("rst_pending", 32'(pending),   32'd0);
      chk("rst_a",       32'(out_a),     32'd0);
      chk("rst_b",       32'(out_b),     32'd0);
      chk("rst_op",      32'(out_op),    32'd0);
      chk("rst_rd",      32'(out_rd),    32'd0);
      cyc();
      rst = 1'b0;
      cyc();

      // Write and issue
      wb(2'd1, 8'd15); cyc();
      wb(2'd2, 8'd8);  cyc();
      wb_en = 1'b0;
      offer(2'd1, 2'd2, 2'd3, OP_SUB);
      push(8'd15, 8'd8, OP_SUB, 2'd3);
      mid(); chk("issue_ready_first", 32'(issue_ready), 32'd1);
      cyc();
      issue_valid = 1'b0;
      mid();
      chk("valid_after_issue", 32'(out_valid), 32'd1);
      chk("pending_r3",        32'(pending),   32'b1000);

      // RAW stall on r3, released by write-back with bypass
      cyc();
      offer(2'd3, 2'd1, 2'd0, OP_ADD);
      for (int i = 0; i < 3; i++) begin
         mid(); chk("raw_stall", 32'(issue_ready), 32'd0);
         cyc();
      end
      wb(2'd3, 8'd7);
      push(8'd7, 8'd15, OP_ADD, 2'd0);
      mid(); chk("raw_release", 32'(issue_ready), 32'd1);
      cyc();
      wb_en = 1'b0; issue_valid = 1'b0;
      mid(); chk("pending_after_raw", 32'(pending), 32'b0001);

      // Wrap values
      cyc();
      wb(2'd0, 8'd255); cyc();
      wb(2'd1, 8'd1);   cyc();
      wb_en = 1'b0;
      mid(); chk("pending_clear", 32'(pending), 32'd0);
      cyc();
      offer(2'd0, 2'd1, 2'd2, OP_ADD);
      push(8'd255, 8'd1, OP_ADD, 2'd2);
      cyc();

      // WAW: second write to r2 waits for its write-back
      offer(2'd1, 2'd1, 2'd2, OP_SUB);
      for (int i = 0; i < 2; i++) begin
         mid(); chk("waw_stall", 32'(issue_ready), 32'd0);
         cyc();
      end
      wb(2'd2, 8'd0);
      push(8'd1, 8'd1, OP_SUB, 2'd2);
      mid(); chk("waw_release", 32'(issue_ready), 32'd1);
      cyc();
      wb_en = 1'b0; issue_valid = 1'b0;
      mid(); chk("pending_waw", 32'(pending), 32'b0100);

      // Backpressure
      cyc();
      wb(2'd2, 8'd254); cyc();
      wb_en = 1'b0;
      out_ready = 1'b0;
      offer(2'd0, 2'd1, 2'd3, OP_SUB);
      push(8'd255, 8'd1, OP_SUB, 2'd3);
      mid(); chk("bp_first_ready", 32'(issue_ready), 32'd1);
      cyc();
      offer(2'd2, 2'd0, 2'd1, OP_ADD);
      for (int i = 0; i < 3; i++) begin
         mid();
         chk("bp_ready", 32'(issue_ready), 32'd0);
         chk("bp_valid", 32'(out_valid),   32'd1);
         chk("bp_a",     32'(out_a),       32'd255);
         chk("bp_b",     32'(out_b),       32'd1);
         chk("bp_rd",    32'(out_rd),      32'd3);
         cyc();
      end
      out_ready = 1'b1;
      push(8'd254, 8'd255, OP_ADD, 2'd1);
      mid(); chk("bp_release", 32'(issue_ready), 32'd1);
      cyc();
      issue_valid = 1'b0;
      mid(); chk("no_bubble", 32'(out_valid), 32'd1);

      // Write-back to a register that is not pending
      cyc();
      wb(2'd0, 8'd5); cyc();
      wb_en = 1'b0;
      mid(); chk("wb_nonpending", 32'(pending), 32'b1010);
      cyc();
      offer(2'd0, 2'd0, 2'd0, OP_ADD);
      push(8'd5, 8'd5, OP_ADD, 2'd0);
      cyc();
      issue_valid = 1'b0;
      mid(); chk("pending_final", 32'(pending), 32'b1011);
      cyc(); cyc();
      mid(); chk("valid_drained", 32'(out_valid), 32'd0);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL timeout observed running expected finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/regfile_issue.md
Name: regfile_issue

Overview:
- Operand-issue stage directly upstream of the 8-bit add/sub ALU.
- Holds a small general-purpose register file and a per-register pending scoreboard.
- Reads two source registers for each issued instruction and presents registered operands a, b and op to the ALU under a valid/ready handshake.
- Accepts the ALU result back through a write-back port; stalls issue on register hazards.

Parameters:
- WIDTH, 8, data width of registers and operands.
- NREGS, 4, number of registers.
- AW, 2, register address width (log2 of NREGS).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  an instruction is offered.
- issue_ready  output  1  instruction accepted this cycle when issue_valid is also high.
- issue_rs_a  input  AW  source register for operand a.
- issue_rs_b  input  AW  source register for operand b.
- issue_rd  input  AW  destination register.
- issue_op  input  1  0 = add, 1 = subtract; passed through to the ALU.
- out_valid  output  1  the a/b/op/rd outputs hold a valid operation.
- out_ready  input  1  downstream consumes the operation.
- out_a  output  WIDTH  operand a to the ALU.
- out_b  output  WIDTH  operand b to the ALU.
- out_op  output  1  op to the ALU.
- out_rd  output  AW  destination tag travelling with the operation.
- wb_en  input  1  write-back strobe.
- wb_addr  input  AW  write-back register.
- wb_data  input  WIDTH  write-back value (the ALU result).
- pending  output  NREGS  scoreboard bits, one per register.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk):
  - all registers = 0; pending = 0; out_valid = 0.
  - out_a, out_b, out_op, out_rd = 0.
  - Reset mid-operation discards any held output and all scoreboard state.
- Hazard is true when any of these bits is set and not being cleared this cycle by wb_en with wb_addr matching:
  - pending[issue_rs_a], pending[issue_rs_b], pending[issue_rd].
  - The issue_rd check blocks write-after-write.
- issue_ready = (!out_valid || out_ready) && !hazard.
  - Combinational from the issue_* inputs, pending, wb_* and out_ready.
  - Must not depend on issue_valid.
- Accept = issue_valid && issue_ready. On accept, at the clock edge:
  - out_a ← value of rs_a, out_b ← value of rs_b; out_op ← issue_op; out_rd ← issue_rd.
  - out_valid ← 1; pending[issue_rd] ← 1.
- Operand bypass: if wb_en && wb_addr == rs_x in the accept cycle, the operand takes wb_data, not the stale register value.
- Latency: one cycle from accept to out_valid.
  - Back-to-back issue is allowed when out_ready is held high and there is no hazard.
- out_valid && !out_ready: out_* stay stable and issue_ready = 0.
- out_ready && !accept: out_valid ← 0 and out_* hold their last values.
- Write-back at the edge when wb_en = 1:
  - reg[wb_addr] ← wb_data; pending[wb_addr] ← 0.
- Write-back and accept on the same cycle with wb_addr == issue_rd: pending ends at 1.
  - Cannot occur under correct use, because a hazard blocks it; the set still takes priority over the clear.
- Write-back to a non-pending register is legal: the register updates and pending stays 0.
- Arithmetic: none in this block; values are stored and forwarded unmodified at WIDTH bits.
- Register 0 is an ordinary writable register (no hardwired zero).

Decomposition:
- Shared package:
  - WIDTH, NREGS, AW.
  - op encoding constants OP_ADD = 0, OP_SUB = 1, shared with the ALU.
- One sub-module is natural: regfile_core.
  - Register array with two combinational read ports and one write port, with the bypass mux.
- Scoreboard, handshake and output register stay in regfile_issue.

Test Plan:
- Reset then idle:
  - Assert rst mid-cycle → out_valid = 0, pending = 0000, out_a = out_b = 0 immediately without a clock edge.
- Write and issue:
  - Write-back r1 = 15, r2 = 8; issue rs_a = 1, rs_b = 2, rd = 3, op = 1.
  - Next cycle: out_valid = 1, out_a = 15, out_b = 8, out_op = 1, out_rd = 3, pending = 1000.
- RAW stall:
  - With pending[3] = 1, offer rs_a = 3 → issue_ready = 0 for as many cycles as no write-back arrives.
  - Write-back r3 = 7 → issue_ready = 1 that same cycle; out_a = 7 next cycle (bypass); pending[3] = 1 again only if rd = 3.
- Backpressure:
  - out_valid = 1, out_ready = 0 for 3 cycles → out_* unchanged, issue_ready = 0.
  - Raise out_ready with a new valid issue → the new operands appear next cycle with no bubble.
- WAW block:
  - Issue rd = 2 twice without write-back → the second issue is stalled until a write-back to r2 occurs.
- Wrap values:
  - Write-back r0 = 255 and r1 = 1; issue a = r0, b = r1 → out_a = 255, out_b = 1 unmodified.
  - Feeding the ALU yields 0 (add) and 254 (sub).
